rip_fetch: RTL and testbench

Instruction fetch stage for the rip-cpu pipeline: the producer end of the `inst_code` / `de_ready` interface consumed by the decode stage. It keeps the fetch PC and issues word reads to a fixed 1-cycle-latency instruction memory. Fetched words are held in a 2-entry prefetch buffer, together with their PCs, until decode accepts them. Redirects from execute (branch, jump, trap, MRET) flush the buffer, discard any in-flight read and restart fetch at the new PC.

---
 rtl/rip_fetch.sv | 187 ++++++++++++++++++
 tb/tb_rip_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rip_fetch.sv
// rip_fetch -- instruction fetch stage of the rip-cpu pipeline.
//
// Keeps the fetch PC and issues word reads to a 1-cycle-latency instruction
// memory. Returned words are queued with their PCs in a 2-entry prefetch
// buffer until decode accepts them. A redirect flushes the buffer, drops any
// response that arrives with it, and restarts fetch at redirect_pc.
//
// Build option: define RIP_FETCH_MISALIGN_CHECK_EN to report misaligned
// redirect targets and halt fetch until an aligned redirect. When it is not
// defined, the low two target bits are cleared and the misalign outputs
// are tied to 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_en/imem_addr  read request and word-aligned address
//   imem_rdata         read data, valid the cycle after imem_en
//   redirect/redirect_pc  flush and restart target
//   de_stall           decode cannot accept this cycle
//   de_ready           inst_code/inst_pc hold a valid instruction
//   inst_code/inst_pc  head of the prefetch buffer (0 when not ready)
//   fetch_misalign     one-cycle pulse on a misaligned redirect target
//   fetch_misalign_pc  offending target, held until the next redirect
module rip_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        de_stall,
    output logic        de_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic        fetch_misalign,
    output logic [31:0] fetch_misalign_pc
);

`ifdef RIP_FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] issue_pc_q, issue_pc_d;
    logic [1:0]  occ_q, occ_d;
    logic        inf_q, inf_d;
    logic        kill_q, kill_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;

    // Prefetch storage; contents are only visible through de_ready gating,
    // so they need no reset.
    logic [31:0] fifo_code_q [BUF_DEPTH];
    logic [31:0] fifo_pc_q   [BUF_DEPTH];

    logic [31:0] target_pc;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  level;

`ifdef RIP_FETCH_MISALIGN_CHECK_EN
    logic        target_bad;
    logic        misalign_q;
    logic [31:0] misalign_pc_q;

    assign target_bad = |redirect_pc[1:0];
    assign target_pc  = redirect_pc;
`else
    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign de_ready = (occ_q != 2'd0) && !redirect;
    assign pop      = de_ready && !de_stall;
    // A response arriving together with a redirect belongs to the old stream.
    assign push     = inf_q && !kill_q && !redirect;

    // Occupancy after this cycle's pop, counting the read in flight; a new
    // issue is allowed only if its response is guaranteed a free slot.
    assign level = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
    assign issue = (state_q == RUN) && !redirect && (level < 3'd2);

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q;
    assign inst_code = de_ready ? fifo_code_q[rd_ptr_q] : '0;
    assign inst_pc   = de_ready ? fifo_pc_q[rd_ptr_q]   : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        occ_d      = occ_q;
        inf_d      = issue;
        kill_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            IDLE: state_d = RUN;
`ifdef RIP_FETCH_MISALIGN_CHECK_EN
            RUN:  if (redirect && target_bad) state_d = HALT;
            HALT: if (redirect && !target_bad) state_d = RUN;
`else
            RUN:  state_d = RUN;
`endif
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = target_pc;
            occ_d      = 2'd0;
            // Marks the outstanding read stale so its data never reaches the buffer.
            kill_d     = inf_q;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                issue_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VECTOR;
            issue_pc_q <= RESET_VECTOR;
            occ_q      <= 2'd0;
            inf_q      <= 1'b0;
            kill_q     <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            occ_q      <= occ_d;
            inf_q      <= inf_d;
            kill_q     <= kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_code_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= issue_pc_q;
        end
    end

`ifdef RIP_FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else begin
            misalign_q <= redirect && target_bad;
            if (redirect) misalign_pc_q <= target_bad ? redirect_pc : '0;
        end
    end

    assign fetch_misalign    = misalign_q;
    assign fetch_misalign_pc = misalign_pc_q;
`else
    assign fetch_misalign    = 1'b0;
    assign fetch_misalign_pc = '0;
`endif

endmodule

// File: tb/tb_rip_fetch.sv
// tb_rip_fetch -- directed self-checking bench for rip_fetch.
// The memory model returns addr ^ 32'hA5A5_0000 one cycle after a read.
module tb_rip_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        de_stall;
    logic        de_ready;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        fetch_misalign;
    logic [31:0] fetch_misalign_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    rip_fetch #(
        .RESET_VECTOR(32'h0000_0100),
        .BUF_DEPTH   (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_en          (imem_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .de_stall         (de_stall),
        .de_ready         (de_ready),
        .inst_code        (inst_code),
        .inst_pc          (inst_pc),
        .fetch_misalign   (fetch_misalign),
        .fetch_misalign_pc(fetch_misalign_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        imem_rdata <= imem_en ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 later.
    task automatic step(input logic stall, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        de_stall    = stall;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic expect_cyc(input logic en, input logic [31:0] addr,
                              input logic rdy, input logic [31:0] pc,
                              input logic mis = 1'b0);
        chk($sformatf("c%0d.imem_en", cyc), {31'b0, imem_en}, {31'b0, en});
        if (en) chk($sformatf("c%0d.imem_addr", cyc), imem_addr, addr);
        chk($sformatf("c%0d.de_ready", cyc), {31'b0, de_ready}, {31'b0, rdy});
        chk($sformatf("c%0d.inst_pc", cyc), inst_pc, rdy ? pc : 32'h0);
        chk($sformatf("c%0d.inst_code", cyc), inst_code, rdy ? (pc ^ 32'hA5A5_0000) : 32'h0);
        chk($sformatf("c%0d.misalign", cyc), {31'b0, fetch_misalign}, {31'b0, mis});
        chk($sformatf("c%0d.occ_le2", cyc), {31'b0, (dut.occ_q <= 2'd2)}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1; de_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst.imem_en",   {31'b0, imem_en}, 32'd0);
        chk("rst.imem_addr", imem_addr, 32'h100);
        chk("rst.de_ready",  {31'b0, de_ready}, 32'd0);
        chk("rst.inst_code", inst_code, 32'h0);
        chk("rst.inst_pc",   inst_pc, 32'h0);
        chk("rst.misalign",  {31'b0, fetch_misalign}, 32'd0);
        chk("rst.mis_pc",    fetch_misalign_pc, 32'h0);
        @(negedge clk); #1;
        chk("rst_hold.imem_en", {31'b0, imem_en}, 32'd0);
        rst_n = 1'b1;   // released before E0

        // Start-up and steady state: issue from cycle 1, data from cycle 3.
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, '0);
            expect_cyc(1'b1, 32'h100 + 32'(4 * (k - 1)), (k >= 3),
                       (k >= 3) ? 32'h100 + 32'(4 * (k - 3)) : 32'h0);
        end

        // Three stall cycles: occ+inf already 2, so issue stops at once.
        step(1'b1, 1'b0, '0); expect_cyc(1'b0, 32'h0, 1'b1, 32'h110);
        step(1'b1, 1'b0, '0); expect_cyc(1'b0, 32'h0, 1'b1, 32'h110);
        step(1'b1, 1'b0, '0); expect_cyc(1'b0, 32'h0, 1'b1, 32'h110);
        chk("stall.occ", {30'b0, dut.occ_q}, 32'd2);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h118, 1'b1, 32'h110);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h11C, 1'b1, 32'h114);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h120, 1'b1, 32'h118);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h124, 1'b1, 32'h11C);

        // Redirect with a stalled head and a read in flight.
        step(1'b1, 1'b1, 32'h200); expect_cyc(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h204, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h208, 1'b1, 32'h200);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h20C, 1'b1, 32'h204);

        // Redirect coinciding with a response arrival and a would-be pop.
        step(1'b0, 1'b1, 32'h400); expect_cyc(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h400, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h404, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h408, 1'b1, 32'h400);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h40C, 1'b1, 32'h404);

        // Misaligned redirect target.
        step(1'b0, 1'b1, 32'h202); expect_cyc(1'b0, 32'h0, 1'b0, 32'h0);
`ifdef RIP_FETCH_MISALIGN_CHECK_EN
        step(1'b0, 1'b0, '0);      expect_cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("mis.pc", fetch_misalign_pc, 32'h202);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("mis.pc_hold", fetch_misalign_pc, 32'h202);
        step(1'b0, 1'b1, 32'h300); expect_cyc(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h300, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h304, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h308, 1'b1, 32'h300);
`else
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h200, 1'b0, 32'h0);
        chk("mis.pc_tied", fetch_misalign_pc, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h204, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0);      expect_cyc(1'b1, 32'h208, 1'b1, 32'h200);
`endif

        // PC wrap from 0xFFFF_FFFC to 0.
        step(1'b0, 1'b1, 32'hFFFF_FFF8); expect_cyc(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, '0); expect_cyc(1'b1, 32'h0000_0008, 1'b1, 32'h0);

        // Fill the buffer, then assert reset between clock edges.
        step(1'b1, 1'b0, '0); expect_cyc(1'b0, 32'h0, 1'b1, 32'h4);
        step(1'b1, 1'b0, '0); expect_cyc(1'b0, 32'h0, 1'b1, 32'h4);
        chk("full.occ", {30'b0, dut.occ_q}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.imem_en",   {31'b0, imem_en}, 32'd0);
        chk("arst.imem_addr", imem_addr, 32'h100);
        chk("arst.de_ready",  {31'b0, de_ready}, 32'd0);
        chk("arst.inst_code", inst_code, 32'h0);
        chk("arst.inst_pc",   inst_pc, 32'h0);
        chk("arst.occ",       {30'b0, dut.occ_q}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
